// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor stepping path.
package enigma_pkg;

  localparam int POS_W       = 5;
  localparam int ROTOR_MAX   = 25;
  localparam int NOTCH_R_DEF = 16;
  localparam int NOTCH_M_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEBOUNCE = 4'd1,
    ST_STEP     = 4'd2,
    ST_SETTLE   = 4'd3,
    ST_ENCODE   = 4'd4,
    ST_WAIT_REL = 4'd5,
    ST_LOAD_R   = 4'd6,
    ST_LOAD_M   = 4'd7,
    ST_LOAD_L   = 4'd8
  } state_e;

  // Switch settings above Z have no rotor meaning and fall back to A.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v);
    if (v > POS_W'(ROTOR_MAX)) begin
      return '0;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/rotor_step_controller_key_debouncer.sv
// Key synchroniser plus a shared stability counter, run in press or release mode by the FSM.
module key_debouncer
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  input  logic cnt_press_i,
  input  logic cnt_release_i,
  output logic key_s_o,
  output logic press_done_o,
  output logic release_done_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             key_s;

  // Two-flop synchroniser; released (high) out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = ~sync2_q;

  // Counter runs only while the key holds the level the current mode waits for.
  always_comb begin
    cnt_d = '0;
    if (cnt_press_i) begin
      cnt_d = key_s ? (cnt_q + CNT_W'(1)) : '0;
    end else if (cnt_release_i) begin
      cnt_d = key_s ? '0 : (cnt_q + CNT_W'(1));
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign key_s_o        = key_s;
  assign press_done_o   = cnt_press_i & key_s & (cnt_q == CNT_LAST);
  assign release_done_o = cnt_release_i & ~key_s & (cnt_q == CNT_LAST);

endmodule

// File: rtl/rotor_step_controller.sv
// Enigma rotor stepping controller: debounced key -> step / settle / encode, plus initial-position load.
module rotor_step_controller
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int NOTCH_R         = NOTCH_R_DEF,
  parameter int NOTCH_M         = NOTCH_M_DEF
) (
  input  logic             CLOCK_50,
  input  logic             RESET_TRUE,
  input  logic             key_n,
  input  logic             load_req,
  input  logic [POS_W-1:0] init_pos_r,
  input  logic [POS_W-1:0] init_pos_m,
  input  logic [POS_W-1:0] init_pos_l,
  input  logic [POS_W-1:0] pos_r,
  input  logic [POS_W-1:0] pos_m,
  input  logic [POS_W-1:0] pos_l,
  output logic             step_r,
  output logic             step_m,
  output logic             step_l,
  output logic             load_r,
  output logic             load_m,
  output logic             load_l,
  output logic [POS_W-1:0] load_val,
  output logic             enc_valid,
  output logic             busy,
  output logic [3:0]       state
);

  state_e state_q;
  logic   key_s;
  logic   press_done_s;
  logic   release_done_s;
  logic   pos_l_unused;

  // The left rotor has no notch of interest to the stepping rule.
  assign pos_l_unused = ^pos_l;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk_i          (CLOCK_50),
    .rst_i          (RESET_TRUE),
    .key_n_i        (key_n),
    .cnt_press_i    (state_q == ST_DEBOUNCE),
    .cnt_release_i  (state_q == ST_WAIT_REL),
    .key_s_o        (key_s),
    .press_done_o   (press_done_s),
    .release_done_o (release_done_s)
  );

  // Sequencer; each strobe is set on the edge that enters its state so it lines up with state.
  always_ff @(posedge CLOCK_50) begin
    if (RESET_TRUE) begin
      state_q   <= ST_IDLE;
      step_r    <= 1'b0;
      step_m    <= 1'b0;
      step_l    <= 1'b0;
      load_r    <= 1'b0;
      load_m    <= 1'b0;
      load_l    <= 1'b0;
      load_val  <= '0;
      enc_valid <= 1'b0;
    end else begin
      step_r    <= 1'b0;
      step_m    <= 1'b0;
      step_l    <= 1'b0;
      load_r    <= 1'b0;
      load_m    <= 1'b0;
      load_l    <= 1'b0;
      load_val  <= '0;
      enc_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            state_q  <= ST_LOAD_R;
            load_r   <= 1'b1;
            load_val <= clamp_pos(init_pos_r);
          end else if (key_s) begin
            state_q <= ST_DEBOUNCE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (!key_s) begin
            state_q <= ST_IDLE;
          end else if (press_done_s) begin
            // Middle notch steps the middle rotor again: the historical double step.
            state_q <= ST_STEP;
            step_r  <= 1'b1;
            step_m  <= (pos_r == POS_W'(NOTCH_R)) || (pos_m == POS_W'(NOTCH_M));
            step_l  <= (pos_m == POS_W'(NOTCH_M));
          end else begin
            state_q <= ST_DEBOUNCE;
          end
        end
        ST_STEP: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state_q   <= ST_ENCODE;
          enc_valid <= 1'b1;
        end
        ST_ENCODE: begin
          state_q <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (release_done_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_REL;
          end
        end
        ST_LOAD_R: begin
          state_q  <= ST_LOAD_M;
          load_m   <= 1'b1;
          load_val <= clamp_pos(init_pos_m);
        end
        ST_LOAD_M: begin
          state_q  <= ST_LOAD_L;
          load_l   <= 1'b1;
          load_val <= clamp_pos(init_pos_l);
        end
        ST_LOAD_L: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rotor_step_controller.sv
// Scoreboard bench: stimulus predicts strobe events from Enigma stepping rules, a monitor checks them.
module tb_rotor_step_controller;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    logic [2:0] step;   // {l, m, r}
    logic [2:0] ld;     // {l, m, r}
    logic [4:0] val;
    logic       enc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       load_req;
  logic [4:0] init_r, init_m, init_l;
  logic [4:0] pos_r, pos_m, pos_l;
  logic       step_r, step_m, step_l;
  logic       load_r, load_m, load_l;
  logic [4:0] load_val;
  logic       enc_valid;
  logic       busy;
  logic [3:0] state;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic mon_en = 1'b0;
  ev_t  sbq[$];

  rotor_step_controller #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (3)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_TRUE (rst),
    .key_n      (key_n),
    .load_req   (load_req),
    .init_pos_r (init_r),
    .init_pos_m (init_m),
    .init_pos_l (init_l),
    .pos_r      (pos_r),
    .pos_m      (pos_m),
    .pos_l      (pos_l),
    .step_r     (step_r),
    .step_m     (step_m),
    .step_l     (step_l),
    .load_r     (load_r),
    .load_m     (load_m),
    .load_l     (load_l),
    .load_val   (load_val),
    .enc_valid  (enc_valid),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] st, input logic [2:0] ld,
                      input logic [4:0] v, input logic e);
    ev_t ev;
    ev.cyc = c; ev.step = st; ev.ld = ld; ev.val = v; ev.enc = e;
    sbq.push_back(ev);
  endtask

  // Enigma rule: right always moves; middle moves if right is at Q or middle at E; left if middle at E.
  function automatic logic [2:0] expect_step(input logic [4:0] r, input logic [4:0] m);
    logic mid_at_e, right_at_q;
    mid_at_e   = (m == 5'd4);
    right_at_q = (r == 5'd16);
    return {mid_at_e, right_at_q | mid_at_e, 1'b1};
  endfunction

  function automatic logic [4:0] expect_load(input logic [4:0] v);
    return (v <= 5'd25) ? v : 5'd0;
  endfunction

  // Monitor: every strobe cycle must match the oldest prediction, including its cycle.
  always @(negedge clk) begin
    ev_t e;
    logic [2:0] gs, gl;
    gs = {step_l, step_m, step_r};
    gl = {load_l, load_m, load_r};
    if (mon_en && ((|{gs, gl, enc_valid}) === 1'b1)) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got step=%b load=%b val=%0d enc=%b at cycle %0d, expected none",
                 gs, gl, load_val, enc_valid, cyc);
      end else begin
        e = sbq.pop_front();
        if (gs !== e.step || gl !== e.ld || load_val !== e.val ||
            enc_valid !== e.enc || cyc != e.cyc) begin
          fails++;
          $display("FAIL event: got step=%b load=%b val=%0d enc=%b cyc=%0d, expected step=%b load=%b val=%0d enc=%b cyc=%0d",
                   gs, gl, load_val, enc_valid, cyc, e.step, e.ld, e.val, e.enc, e.cyc);
        end
      end
    end
  end

  task automatic press(input logic [4:0] r, input logic [4:0] m, input int hold);
    int c;
    @(negedge clk);
    pos_r = r; pos_m = m; pos_l = 5'($urandom_range(0, 25));
    key_n = 1'b0;
    c = cyc;
    push(c + N + 3, expect_step(r, m), 3'b000, 5'd0, 1'b0);
    push(c + N + 5, 3'b000, 3'b000, 5'd0, 1'b1);
    repeat (hold) @(negedge clk);
    chk("busy_while_held", busy, 1);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("state_idle_after_release", state, 0);
    chk("busy_idle_after_release", busy, 0);
  endtask

  // Load with the key pressed at the same moment: the key is only seen once the load is over.
  task automatic do_load(input logic [4:0] ir, input logic [4:0] im, input logic [4:0] il,
                         input logic [4:0] r, input logic [4:0] m);
    int c;
    @(negedge clk);
    init_r = ir; init_m = im; init_l = il;
    pos_r = r; pos_m = m;
    load_req = 1'b1;
    key_n = 1'b0;
    c = cyc;
    push(c + 1, 3'b000, 3'b001, expect_load(ir), 1'b0);
    push(c + 2, 3'b000, 3'b010, expect_load(im), 1'b0);
    push(c + 3, 3'b000, 3'b100, expect_load(il), 1'b0);
    push(c + 5 + N, expect_step(r, m), 3'b000, 5'd0, 1'b0);
    push(c + 7 + N, 3'b000, 3'b000, 5'd0, 1'b1);
    @(negedge clk);
    load_req = 1'b0;
    repeat (11) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("state_idle_after_load", state, 0);
  endtask

  initial begin
    rst = 1'b1; key_n = 1'b1; load_req = 1'b0;
    init_r = 5'd0; init_m = 5'd0; init_l = 5'd0;
    pos_r = 5'd0; pos_m = 5'd0; pos_l = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_step", int'({step_l, step_m, step_r}), 0);
    chk("rst_load", int'({load_l, load_m, load_r}), 0);
    chk("rst_load_val", load_val, 0);
    chk("rst_enc", enc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    press(5'd0, 5'd0, 12);
    press(5'd16, 5'd0, 12);
    press(5'd5, 5'd4, 12);

    // Bounce shorter than the debounce window
    @(negedge clk); key_n = 1'b0;
    repeat (2) @(negedge clk); key_n = 1'b1;
    @(negedge clk); key_n = 1'b0;
    repeat (2) @(negedge clk); key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_state_idle", state, 0);
    chk("bounce_no_pending", sbq.size(), 0);

    do_load(5'd3, 5'd7, 5'd30, 5'd16, 5'd4);

    for (int i = 0; i < 16; i++) begin
      logic [4:0] r, m;
      r = ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 25));
      m = ($urandom_range(0, 3) == 0) ? 5'd4  : 5'($urandom_range(0, 25));
      press(r, m, $urandom_range(5, 14));
    end

    for (int i = 0; i < 3; i++) begin
      do_load(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
